// File: rtl/rv_pkg.sv
// Shared constants for the RV32 subset multi-cycle controller:
// opcodes, ALU control codes and FSM state encodings.
package rv_pkg;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

endpackage

// File: rtl/rv_multicycle_ctrl_if.sv
// Unified memory port handshake between the controller and the memory.
interface rv_multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/rv_alu_dec.sv
// Instruction legality check and ALU operation select, shared by DECODE and EXEC.
module rv_alu_dec
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case ({funct7b5, funct3})
                    4'b0000: begin alu_ctrl = ALU_ADD; legal = 1'b1; end
                    4'b1000: begin alu_ctrl = ALU_SUB; legal = 1'b1; end
                    4'b0111: begin alu_ctrl = ALU_AND; legal = 1'b1; end
                    4'b0110: begin alu_ctrl = ALU_OR;  legal = 1'b1; end
                    default: ;
                endcase
            end
            OP_LOAD, OP_STORE: legal = (funct3 == 3'b010);
            OP_BRANCH: begin
                alu_ctrl = ALU_SUB;
                legal    = (funct3 == 3'b000);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer sharing one memory port,
// with memory-timeout and illegal-instruction trap.
module rv_multicycle_ctrl
    import rv_pkg::*;
#(
    parameter int TIMEOUT   = 15,
    parameter int TIMEOUT_W = 4
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [6:0]                  opcode,
    input  logic [2:0]                  funct3,
    input  logic                        funct7b5,
    input  logic                        zero,
    rv_multicycle_ctrl_if.master        mem,
    output logic                        ir_load,
    output logic                        pc_en,
    output logic                        pc_src,
    output logic                        alu_src_b,
    output logic [3:0]                  alu_ctrl,
    output logic                        rf_we,
    output logic                        wb_sel,
    output logic                        retire,
    output logic                        trap,
    output logic [2:0]                  state_o
);

    localparam logic [TIMEOUT_W-1:0] LAST_WAIT = TIMEOUT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_t               state, state_nxt;
    logic [TIMEOUT_W-1:0] wait_cnt;
    logic                 trap_q;
    logic [3:0]           dec_alu;
    logic                 dec_legal;
    logic                 timed_out;

    rv_alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7b5 (funct7b5),
        .alu_ctrl (dec_alu),
        .legal    (dec_legal)
    );

    // wait_cnt counts completed request cycles without mem_ready
    assign timed_out = (TIMEOUT != 0) && (wait_cnt == LAST_WAIT);

    always_comb begin
        state_nxt     = state;
        mem.mem_req   = 1'b0;
        mem.mem_we    = 1'b0;
        mem.addr_sel  = 1'b0;
        ir_load       = 1'b0;
        pc_en         = 1'b0;
        pc_src        = 1'b0;
        alu_src_b     = 1'b0;
        alu_ctrl      = 4'b0000;
        rf_we         = 1'b0;
        wb_sel        = 1'b0;
        retire        = 1'b0;
        case (state)
            S_FETCH: begin
                mem.mem_req = 1'b1;
                if (mem.mem_ready) begin
                    ir_load   = 1'b1;
                    pc_en     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                end
            end
            S_DECODE: state_nxt = dec_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                alu_ctrl = dec_alu;
                if (opcode == OP_LOAD || opcode == OP_STORE) begin
                    alu_src_b = 1'b1;
                    state_nxt = S_MEM;
                end else if (opcode == OP_BRANCH) begin
                    retire    = 1'b1;
                    pc_en     = zero;
                    pc_src    = zero;
                    state_nxt = S_FETCH;
                end else if (opcode == OP_RTYPE) begin
                    state_nxt = S_WB;
                end else begin
                    state_nxt = S_FETCH;
                end
            end
            S_MEM: begin
                mem.mem_req  = 1'b1;
                mem.addr_sel = 1'b1;
                mem.mem_we   = (opcode == OP_STORE);
                alu_src_b    = 1'b1;
                alu_ctrl     = ALU_ADD;
                if (mem.mem_ready) begin
                    retire    = (opcode == OP_STORE);
                    state_nxt = (opcode == OP_STORE) ? S_FETCH : S_WB;
                end else if (timed_out) begin
                    state_nxt = S_TRAP;
                end
            end
            S_WB: begin
                rf_we     = 1'b1;
                wb_sel    = (opcode == OP_LOAD);
                alu_src_b = (opcode == OP_LOAD);
                alu_ctrl  = dec_alu;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP:  state_nxt = S_TRAP;
            default: state_nxt = S_FETCH;
        endcase

        if (reset) begin
            state_nxt    = S_FETCH;
            mem.mem_req  = 1'b0;
            mem.mem_we   = 1'b0;
            mem.addr_sel = 1'b0;
            ir_load      = 1'b0;
            pc_en        = 1'b0;
            pc_src       = 1'b0;
            alu_src_b    = 1'b0;
            alu_ctrl     = 4'b0000;
            rf_we        = 1'b0;
            wb_sel       = 1'b0;
            retire       = 1'b0;
        end
    end

    // Any cycle that is not a stalled request clears the counter, so it is
    // always zero on entry to FETCH or MEM.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FETCH;
            wait_cnt <= '0;
            trap_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (mem.mem_req && !mem.mem_ready)
                wait_cnt <= wait_cnt + TIMEOUT_W'(1);
            else
                wait_cnt <= '0;
            if (state_nxt == S_TRAP)
                trap_q <= 1'b1;
        end
    end

    assign trap    = trap_q & ~reset;
    assign state_o = reset ? 3'd0 : state;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Randomized instruction-level bench for rv_multicycle_ctrl against a per-instruction cycle model.
module tb_rv_multicycle_ctrl;
    import rv_pkg::*;

    localparam int TMO = 15;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       ir_load, pc_en, pc_src, alu_src_b, rf_we, wb_sel, retire, trap;
    logic [3:0] alu_ctrl;
    logic [2:0] state_o;

    rv_multicycle_ctrl_if mem_bus ();

    rv_multicycle_ctrl #(.TIMEOUT(TMO), .TIMEOUT_W(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .opcode    (opcode),
        .funct3    (funct3),
        .funct7b5  (funct7b5),
        .zero      (zero),
        .mem       (mem_bus),
        .ir_load   (ir_load),
        .pc_en     (pc_en),
        .pc_src    (pc_src),
        .alu_src_b (alu_src_b),
        .alu_ctrl  (alu_ctrl),
        .rf_we     (rf_we),
        .wb_sel    (wb_sel),
        .retire    (retire),
        .trap      (trap),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic [17:0] v;
    } cyc_t;

    cyc_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic logic [17:0] obs();
        return {state_o, mem_bus.mem_req, mem_bus.mem_we, mem_bus.addr_sel, ir_load, pc_en,
                pc_src, alu_src_b, alu_ctrl, rf_we, wb_sel, retire, trap};
    endfunction

    function automatic logic [17:0] mk(input int st, input bit req, input bit we, input bit asel,
                                       input bit irl, input bit pce, input bit pcs, input bit asb,
                                       input logic [3:0] alu, input bit rfwe, input bit wbs,
                                       input bit ret, input bit trp);
        logic [2:0] s3;
        s3 = 3'(st);
        return {s3, req, we, asel, irl, pce, pcs, asb, alu, rfwe, wbs, ret, trp};
    endfunction

    function automatic bit is_legal(input logic [6:0] opc, input logic [2:0] f3, input logic f7);
        if (opc == 7'b0110011)
            return ({f7, f3} == 4'b0000) || ({f7, f3} == 4'b1000) ||
                   ({f7, f3} == 4'b0111) || ({f7, f3} == 4'b0110);
        if (opc == 7'b0000011 || opc == 7'b0100011) return f3 == 3'b010;
        if (opc == 7'b1100011) return f3 == 3'b000;
        return 1'b0;
    endfunction

    function automatic logic [3:0] rtype_alu(input logic f7, input logic [2:0] f3);
        case ({f7, f3})
            4'b1000: return 4'b0110;
            4'b0111: return 4'b0000;
            4'b0110: return 4'b0001;
            default: return 4'b0010;
        endcase
    endfunction

    task automatic check_vec(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (state|req we asel irl pce pcs asb|alu|rfwe wbs ret trp)",
                     tag, got, exp);
        end
    endtask

    task automatic push(input logic rdy, input logic [17:0] v);
        cyc_t c;
        c.rdy = rdy;
        c.v   = v;
        q.push_back(c);
    endtask

    task automatic apply(input string name);
        foreach (q[i]) begin
            mem_bus.mem_ready = q[i].rdy;
            #1;
            check_vec($sformatf("%s cyc%0d", name, i + 1), obs(), q[i].v);
            @(posedge clk);
            #1;
        end
        q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_bus.mem_ready = 1'b1;
        #1;
        check_vec("reset outputs", obs(), 18'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Memory request phase: ready arrives after 'dly' wait cycles unless that exceeds the timeout.
    task automatic push_req(input int st, input bit we, input bit asel, input bit asb,
                            input logic [3:0] alu, input int dly, input logic [17:0] accept_v,
                            output bit trapped);
        trapped = 1'b0;
        for (int c = 0; c < TMO; c++) begin
            if (c == dly) begin
                push(1'b1, accept_v);
                return;
            end
            push(1'b0, mk(st, 1, we, asel, 0, 0, 0, asb, alu, 0, 0, 0, 0));
        end
        trapped = 1'b1;
    endtask

    task automatic push_trap();
        for (int i = 0; i < 3; i++)
            push(1'($urandom), mk(5, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 1));
    endtask

    task automatic run_instr(input string name, input logic [6:0] opc, input logic [2:0] f3,
                             input logic f7, input logic z, input int df, input int dm);
        bit trapped;
        opcode = opc; funct3 = f3; funct7b5 = f7; zero = z;
        push_req(0, 0, 0, 0, 4'b0000, df, mk(0, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0), trapped);
        if (!trapped) begin
            push(1'($urandom), mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
            if (!is_legal(opc, f3, f7)) begin
                trapped = 1'b1;
            end else if (opc == 7'b0110011) begin
                push(1'($urandom), mk(2, 0, 0, 0, 0, 0, 0, 0, rtype_alu(f7, f3), 0, 0, 0, 0));
                push(1'($urandom), mk(4, 0, 0, 0, 0, 0, 0, 0, rtype_alu(f7, f3), 1, 0, 1, 0));
            end else if (opc == 7'b1100011) begin
                push(1'($urandom), mk(2, 0, 0, 0, 0, z, z, 0, 4'b0110, 0, 0, 1, 0));
            end else begin
                bit st = (opc == 7'b0100011);
                push(1'($urandom), mk(2, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0));
                push_req(3, st, 1, 1, 4'b0010, dm,
                         mk(3, 1, st, 1, 0, 0, 0, 1, 4'b0010, 0, 0, st, 0), trapped);
                if (!trapped && !st)
                    push(1'($urandom), mk(4, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 1, 1, 1, 0));
            end
        end
        if (trapped) push_trap();
        apply(name);
        if (trapped) do_reset();
    endtask

    function automatic int rand_delay();
        if ($urandom_range(0, 9) == 0) return $urandom_range(13, 16);
        return $urandom_range(0, 3);
    endfunction

    initial begin
        bit dummy;
        reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0; zero = 1'b0;
        mem_bus.mem_ready = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        run_instr("lw 0-wait",   7'b0000011, 3'b010, 1'b0, 1'b0, 0, 0);
        run_instr("sub",         7'b0110011, 3'b000, 1'b1, 1'b0, 0, 0);
        run_instr("and",         7'b0110011, 3'b111, 1'b0, 1'b1, 0, 0);
        run_instr("or",          7'b0110011, 3'b110, 1'b0, 1'b0, 0, 0);
        run_instr("add",         7'b0110011, 3'b000, 1'b0, 1'b0, 1, 0);
        run_instr("beq taken",   7'b1100011, 3'b000, 1'b0, 1'b1, 0, 0);
        run_instr("beq not",     7'b1100011, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("sw mem+3",    7'b0100011, 3'b010, 1'b0, 1'b0, 0, 3);
        run_instr("fetch tmo",   7'b0000011, 3'b010, 1'b0, 1'b0, 15, 0);
        run_instr("fetch c15",   7'b0000011, 3'b010, 1'b0, 1'b0, 14, 14);
        run_instr("mem tmo",     7'b0100011, 3'b010, 1'b0, 1'b0, 0, 15);
        run_instr("ill 7f",      7'b1111111, 3'b000, 1'b0, 1'b0, 0, 0);
        run_instr("ill r 1,111", 7'b0110011, 3'b111, 1'b1, 1'b0, 0, 0);

        // reset while sw is waiting in MEM
        opcode = 7'b0100011; funct3 = 3'b010; funct7b5 = 1'b0;
        push_req(0, 0, 0, 0, 4'b0000, 0, mk(0, 1, 0, 0, 1, 1, 0, 0, 4'b0000, 0, 0, 0, 0), dummy);
        push(1'b0, mk(1, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        push(1'b0, mk(2, 0, 0, 0, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0));
        push(1'b0, mk(3, 1, 1, 1, 0, 0, 0, 1, 4'b0010, 0, 0, 0, 0));
        apply("sw pre-reset");
        do_reset();
        push(1'b0, mk(0, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0, 0, 0, 0));
        apply("after mem reset");

        for (int n = 0; n < 250; n++) begin
            int k;
            logic [6:0] opc;
            logic [2:0] f3;
            logic f7;
            k = $urandom_range(0, 7);
            f7 = 1'b0;
            case (k)
                0: begin opc = 7'b0110011; f3 = 3'b000; end
                1: begin opc = 7'b0110011; f3 = 3'b000; f7 = 1'b1; end
                2: begin opc = 7'b0110011; f3 = 3'b111; end
                3: begin opc = 7'b0110011; f3 = 3'b110; end
                4: begin opc = 7'b0000011; f3 = 3'b010; end
                5: begin opc = 7'b0100011; f3 = 3'b010; end
                6: begin opc = 7'b1100011; f3 = 3'b000; end
                default: begin
                    case ($urandom_range(0, 4))
                        0: opc = 7'b0110011;
                        1: opc = 7'b0000011;
                        2: opc = 7'b0100011;
                        3: opc = 7'b1100011;
                        default: opc = 7'($urandom);
                    endcase
                    f3 = 3'($urandom);
                    f7 = 1'($urandom);
                end
            endcase
            run_instr($sformatf("rnd%0d", n), opc, f3, f7, 1'($urandom), rand_delay(), rand_delay());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
